display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000, clock cycles each digit is driven (legal range 2..2^20).
REQ-002 SHALL have port CLOCK_50  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port bcd_in  input  16  four BCD digits: [3:0] digit0 (rightmost) .. [15:12] digit3.
REQ-005 SHALL have port load_valid  input  1  requester offers bcd_in.
REQ-006 SHALL have port load_ready  output  1  controller can accept bcd_in.
REQ-007 SHALL have port blank_lz  input  1  enables leading-zero blanking.
REQ-008 SHALL have port seg  output  7  shared segment bus, active-low, bit order as HEX0 (bit0 = a .. bit6 = g).
REQ-009 SHALL have port an  output  4  digit enables, active-low, an[i] selects digit i.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when a pending value is committed.

Function
REQ-011 SHALL run a prescaler counting 0..DIV-1 and wrapping to 0; tick is high in the cycle the count equals DIV-1.
REQ-012 SHALL hold digit index 0..3, advancing by one on tick, wrapping 3->0.
REQ-013 SHALL time-share one BCD-to-7-segment decoder across the four digits; the decoder input is the selected nibble of the shadow register.
REQ-014 SHALL register seg and an; both reflect a new digit index exactly one cycle after the index changes, never mixing digits.
REQ-015 SHALL drive seg to 7'b1111111 for any nibble 10..15 (blank code = 15).
REQ-016 SHALL, when blank_lz=1, replace digit i (i=3,2,1) with code 15 if digit i and all higher digits are zero; digit0 is never blanked.
REQ-017 SHALL implement FSM states EMPTY, SHOW and PEND.
REQ-018 EMPTY: an=4'b1111, seg=7'b1111111, load_ready=1; accept (load_valid&load_ready) -> PEND.
REQ-019 SHOW: scans the shadow register, load_ready=1; accept -> PEND.
REQ-020 PEND: load_ready=0; keeps scanning the old shadow value, or stays blank if entered from EMPTY; on tick with index=3 (frame boundary) -> SHOW.
REQ-021 SHALL capture bcd_in into a pending register on the accept cycle; bcd_in is ignored at all other times.
REQ-022 SHALL copy pending to shadow at the frame boundary in PEND and assert frame_done in the next cycle; the first digit of the new value drives the display when the index wraps to 0.
REQ-023 SHALL treat an accept coinciding with a frame boundary as a new accept: the value is committed at the following frame boundary, not the current one.
REQ-024 SHALL make load_ready combinational from state only, never dependent on load_valid.
REQ-025 SHALL keep the prescaler free-running in all states, so frame timing is independent of loads.

Reset
REQ-026 SHALL, on rst=1, immediately set: state=EMPTY, prescaler=0, index=0, pending=0, shadow=0, an=4'b1111, seg=7'b1111111, frame_done=0, load_ready=1.
REQ-027 SHALL, on rst asserted mid-frame or in PEND, discard the pending value with no frame_done pulse.
REQ-028 SHALL start the first tick DIV cycles after rst deasserts.

Structure
REQ-029 SHALL take state encodings (EMPTY/SHOW/PEND), BLANK_CODE=4'hF and SEG_OFF=7'b1111111 from a shared package display_pkg.
REQ-030 SHALL instantiate exactly one existing myBCDto7Seg as its only sub-module; no second decoder copy.

Verification (DIV=4)
REQ-031 SHALL test reset: assert rst mid-scan -> an=1111, seg=1111111 and load_ready=1 in the same cycle; first tick after 4 cycles.
REQ-032 SHALL test load: accept 16'h1234 in EMPTY -> load_ready=0, frame_done pulses after the next index-3 tick; following frame shows an=1110/seg=0011001, 1101/0110000, 1011/0100100, 0111/1111001.
REQ-033 SHALL test blanking: load 16'h0070 with blank_lz=1 -> digits 3 and 2 seg=1111111, digit1=1111000, digit0=1000000; with blank_lz=0, digits 3 and 2 show 1000000.
REQ-034 SHALL test backpressure: hold load_valid with 16'h5555 then 16'h9999 while in PEND -> only 16'h5555 is captured; load_ready rises only after frame_done.
REQ-035 SHALL test the simultaneous case: accept 16'h0008 exactly on an index-3 tick from SHOW -> old value remains for one more full frame, then 8 is shown.
REQ-036 SHALL test an invalid nibble: load 16'hA000 with blank_lz=0 -> digit3 seg=1111111, others 1000000.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed four-digit display scanner.
package display_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SHOW  = 2'd1,
      PEND  = 2'd2
   } state_t;

   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam logic [6:0] SEG_OFF    = 7'b1111111;

   // Active-low digit enable for the selected digit position.
   function automatic logic [3:0] an_select(input logic [1:0] idx);
      an_select = ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/myBCDto7Seg.sv
// BCD to active-low seven-segment decoder, HEX0 bit order (bit0 = a .. bit6 = g).
module myBCDto7Seg
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (bcd)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with a pending/shadow double buffer.
// Handshake: a value is taken when load_valid && load_ready on a rising edge; load_ready depends on state only.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int DIV = 50000
)
(
   input  logic        CLOCK_50,
   input  logic        rst,
   input  logic [15:0] bcd_in,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_done
);

   localparam int               CNT_W   = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [15:0]      pending, shadow;
   logic             shadow_valid;
   logic             tick, accept, commit;
   logic [3:0]       nibble, code;
   logic             lead_zero;
   logic [6:0]       seg_dec;

   assign tick   = (cnt == CNT_MAX);
   assign commit = (state == PEND) && tick && (idx == 2'd3);
   assign accept = load_valid && load_ready;

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (tick) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      case (state)
         EMPTY, SHOW: begin
            load_ready = 1'b1;
            if (load_valid) state_nxt = PEND;
         end
         PEND: begin
            if (commit) state_nxt = SHOW;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // shadow_valid stays low until the first commit, so PEND entered from EMPTY stays dark.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         pending      <= 16'h0000;
         shadow       <= 16'h0000;
         shadow_valid <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= commit;
         if (accept) pending <= bcd_in;
         if (commit) begin
            shadow       <= pending;
            shadow_valid <= 1'b1;
         end
      end
   end

   always_comb begin
      nibble    = shadow[3:0];
      lead_zero = 1'b0;
      case (idx)
         2'd0: nibble = shadow[3:0];
         2'd1: begin
            nibble    = shadow[7:4];
            lead_zero = (shadow[15:4] == 12'h000);
         end
         2'd2: begin
            nibble    = shadow[11:8];
            lead_zero = (shadow[15:8] == 8'h00);
         end
         default: begin
            nibble    = shadow[15:12];
            lead_zero = (shadow[15:12] == 4'h0);
         end
      endcase
   end

   assign code = (blank_lz && lead_zero) ? BLANK_CODE : nibble;

   myBCDto7Seg u_dec (
      .bcd (code),
      .seg (seg_dec)
   );

   // an and seg are registered together from the same index, so they never mix digits.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         an  <= 4'b1111;
         seg <= SEG_OFF;
      end else if (shadow_valid) begin
         an  <= an_select(idx);
         seg <= seg_dec;
      end else begin
         an  <= 4'b1111;
         seg <= SEG_OFF;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIV=4 (16-cycle frames).
module tb_display_scan_ctrl;

   logic        CLOCK_50;
   logic        rst;
   logic [15:0] bcd_in;
   logic        load_valid;
   logic        load_ready;
   logic        blank_lz;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   display_scan_ctrl #(.DIV(4)) dut (
      .CLOCK_50   (CLOCK_50),
      .rst        (rst),
      .bcd_in     (bcd_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_digit(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
      chk({tag, "_an"}, {12'h000, an}, {12'h000, exp_an});
      chk({tag, "_seg"}, {9'h000, seg}, {9'h000, exp_seg});
   endtask

   task automatic wait_done(input string tag, input int exp_steps);
      int n = 0;
      while (frame_done !== 1'b1 && n < 40) begin
         step(1);
         n++;
      end
      chk({tag, "_done"}, {15'h0000, frame_done}, 16'h0001);
      chk({tag, "_latency"}, 16'(n), 16'(exp_steps));
   endtask

   initial begin
      rst        = 1'b1;
      bcd_in     = 16'h0000;
      load_valid = 1'b0;
      blank_lz   = 1'b0;
      #1;
      chk_digit("reset", 4'b1111, 7'b1111111);
      chk("reset_ready", {15'h0000, load_ready}, 16'h0001);
      chk("reset_done", {15'h0000, frame_done}, 16'h0000);
      step(2);
      rst = 1'b0;

      // Load 1234 from EMPTY in the first cycle after reset.
      chk("t1_ready_idle", {15'h0000, load_ready}, 16'h0001);
      bcd_in     = 16'h1234;
      load_valid = 1'b1;
      step(1);
      load_valid = 1'b0;
      bcd_in     = 16'hFFFF;
      chk("t1_ready_pend", {15'h0000, load_ready}, 16'h0000);
      chk_digit("t1_pend_blank", 4'b1111, 7'b1111111);
      wait_done("t1", 15);
      chk("t1_ready_show", {15'h0000, load_ready}, 16'h0001);
      chk_digit("t1_wrap", 4'b1111, 7'b1111111);
      step(1);
      chk("t1_pulse_end", {15'h0000, frame_done}, 16'h0000);
      chk_digit("t1_d0", 4'b1110, 7'b0011001);
      step(4);
      chk_digit("t1_d1", 4'b1101, 7'b0110000);
      step(4);
      chk_digit("t1_d2", 4'b1011, 7'b0100100);
      step(4);
      chk_digit("t1_d3", 4'b0111, 7'b1111001);

      // Reset asserted mid-scan takes effect without a clock edge.
      rst = 1'b1;
      #1;
      chk_digit("rst_mid", 4'b1111, 7'b1111111);
      chk("rst_mid_ready", {15'h0000, load_ready}, 16'h0001);
      step(1);
      rst = 1'b0;

      // Reset while PEND discards the pending value.
      bcd_in     = 16'h1111;
      load_valid = 1'b1;
      step(1);
      load_valid = 1'b0;
      chk("discard_ready_pend", {15'h0000, load_ready}, 16'h0000);
      step(5);
      rst = 1'b1;
      #1;
      chk("discard_ready_rst", {15'h0000, load_ready}, 16'h0001);
      step(1);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("discard_idle", {11'h000, frame_done, an}, 16'h000F);
         step(1);
      end
      rst = 1'b1;
      step(1);
      rst = 1'b0;

      // Leading-zero blanking on 0070, then the same value unblanked.
      blank_lz   = 1'b1;
      bcd_in     = 16'h0070;
      load_valid = 1'b1;
      step(1);
      load_valid = 1'b0;
      wait_done("t3", 15);
      step(1);
      chk_digit("lz_d0", 4'b1110, 7'b1000000);
      step(4);
      chk_digit("lz_d1", 4'b1101, 7'b1111000);
      step(4);
      chk_digit("lz_d2", 4'b1011, 7'b1111111);
      step(4);
      chk_digit("lz_d3", 4'b0111, 7'b1111111);
      blank_lz = 1'b0;
      step(4);
      chk_digit("nolz_d0", 4'b1110, 7'b1000000);
      step(4);
      chk_digit("nolz_d1", 4'b1101, 7'b1111000);
      step(4);
      chk_digit("nolz_d2", 4'b1011, 7'b1000000);
      step(4);
      chk_digit("nolz_d3", 4'b0111, 7'b1000000);

      // Backpressure: 5555 taken from SHOW, 9999 held while PEND must be ignored.
      chk("bp_ready_show", {15'h0000, load_ready}, 16'h0001);
      bcd_in     = 16'h5555;
      load_valid = 1'b1;
      step(1);
      bcd_in = 16'h9999;
      chk("bp_ready_pend0", {15'h0000, load_ready}, 16'h0000);
      step(1);
      chk("bp_ready_pend1", {15'h0000, load_ready}, 16'h0000);
      chk("bp_no_done_yet", {15'h0000, frame_done}, 16'h0000);
      step(1);
      chk("bp_done", {15'h0000, frame_done}, 16'h0001);
      chk("bp_ready_after", {15'h0000, load_ready}, 16'h0001);
      load_valid = 1'b0;
      step(1);
      chk_digit("bp_d0", 4'b1110, 7'b0010010);
      step(4);
      chk_digit("bp_d1", 4'b1101, 7'b0010010);
      step(4);
      chk_digit("bp_d2", 4'b1011, 7'b0010010);
      step(4);
      chk_digit("bp_d3", 4'b0111, 7'b0010010);

      // Accept exactly on the index-3 tick: committed one frame later.
      step(2);
      blank_lz   = 1'b1;
      bcd_in     = 16'h0008;
      load_valid = 1'b1;
      chk("sim_ready", {15'h0000, load_ready}, 16'h0001);
      step(1);
      load_valid = 1'b0;
      chk("sim_no_done", {15'h0000, frame_done}, 16'h0000);
      chk("sim_ready_pend", {15'h0000, load_ready}, 16'h0000);
      step(1);
      chk_digit("sim_old_d0", 4'b1110, 7'b0010010);
      step(4);
      chk_digit("sim_old_d1", 4'b1101, 7'b0010010);
      step(4);
      chk_digit("sim_old_d2", 4'b1011, 7'b0010010);
      step(4);
      chk_digit("sim_old_d3", 4'b0111, 7'b0010010);
      step(2);
      chk("sim_not_early", {15'h0000, frame_done}, 16'h0000);
      step(1);
      chk("sim_done", {15'h0000, frame_done}, 16'h0001);
      step(1);
      chk_digit("sim_new_d0", 4'b1110, 7'b0000000);
      step(4);
      chk_digit("sim_new_d1", 4'b1101, 7'b1111111);
      step(4);
      chk_digit("sim_new_d2", 4'b1011, 7'b1111111);
      step(4);
      chk_digit("sim_new_d3", 4'b0111, 7'b1111111);

      // Non-BCD nibble decodes to all segments off.
      blank_lz   = 1'b0;
      bcd_in     = 16'hA000;
      load_valid = 1'b1;
      step(1);
      load_valid = 1'b0;
      chk("inv_ready_pend", {15'h0000, load_ready}, 16'h0000);
      step(2);
      chk("inv_done", {15'h0000, frame_done}, 16'h0001);
      step(1);
      chk_digit("inv_d0", 4'b1110, 7'b1000000);
      step(4);
      chk_digit("inv_d1", 4'b1101, 7'b1000000);
      step(4);
      chk_digit("inv_d2", 4'b1011, 7'b1000000);
      step(4);
      chk_digit("inv_d3", 4'b0111, 7'b1111111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
